mem: RTL

- MEM stage of the 5-stage RV32I pipeline, directly upstream of the write-back stage.
- Holds the EX/MEM pipeline register and drives a ready/valid data-memory port.
- Formats store byte-lanes and sign/zero-extends load data.
- Stalls the pipeline while a memory access is outstanding.
- Presents ALU result, load data, destination address, PC+4, result_src and reg_write to write-back.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/reg_mem.sv | 49 ++++
 rtl/mem.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Encodings shared across the RV32I pipeline stages: result select,
// load/store funct3 codes and the MEM-stage access FSM states.
package riscv_pkg;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      ABORT = 2'd2
   } mem_state_t;

endpackage

// File: rtl/reg_mem.sv
// EX/MEM pipeline register; loads when en=1, holds otherwise, and
// resets to a bubble so nothing downstream writes the register file.
module reg_mem (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        reg_write_d,
   input  logic [1:0]  result_src_d,
   input  logic        mem_write_d,
   input  logic [2:0]  funct3_d,
   input  logic [31:0] alu_result_d,
   input  logic [31:0] write_data_d,
   input  logic [11:7] addr_des_d,
   input  logic [31:0] pc_plus4_d,
   output logic        reg_write_q,
   output logic [1:0]  result_src_q,
   output logic        mem_write_q,
   output logic [2:0]  funct3_q,
   output logic [31:0] alu_result_q,
   output logic [31:0] write_data_q,
   output logic [11:7] addr_des_q,
   output logic [31:0] pc_plus4_q
);

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every field is reset, not just the control bits, so the bubble
      // presents all-zero outputs; state updates use non-blocking assignment.
      if (!rst_n) begin
         reg_write_q  <= 1'b0;
         result_src_q <= 2'b00;
         mem_write_q  <= 1'b0;
         funct3_q     <= 3'b000;
         alu_result_q <= 32'h0;
         write_data_q <= 32'h0;
         addr_des_q   <= 5'd0;
         pc_plus4_q   <= 32'h0;
      end else if (en) begin
         reg_write_q  <= reg_write_d;
         result_src_q <= result_src_d;
         mem_write_q  <= mem_write_d;
         funct3_q     <= funct3_d;
         alu_result_q <= alu_result_d;
         write_data_q <= write_data_d;
         addr_des_q   <= addr_des_d;
         pc_plus4_q   <= pc_plus4_d;
      end
   end

endmodule

// File: rtl/mem.sv
// MEM stage: EX/MEM register, ready/valid data-memory port with timeout,
// store lane formatting and load extension feeding write-back.
module mem
   import riscv_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_reg_write_EX,
   input  logic [1:0]  i_result_src_EX,
   input  logic        i_mem_write_EX,
   input  logic [2:0]  i_funct3_EX,
   input  logic [31:0] i_alu_result_EX,
   input  logic [31:0] i_write_data_EX,
   input  logic [11:7] i_addr_des_EX,
   input  logic [31:0] i_pc_plus4_EX,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [3:0]  o_dmem_be,
   output logic [31:0] o_dmem_wdata,
   input  logic        i_dmem_ready,
   input  logic [31:0] i_dmem_rdata,
   output logic        o_reg_write_MEM,
   output logic [1:0]  o_result_src_MEM,
   output logic [31:0] o_alu_result_MEM,
   output logic [31:0] o_data_MEM,
   output logic [11:7] o_addr_des_MEM,
   output logic [31:0] o_pc_plus4_MEM,
   output logic        o_stall_MEM,
   output logic        o_misalign,
   output logic        o_bus_err
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   logic        reg_write;
   logic [1:0]  result_src;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] alu_result;
   logic [31:0] write_data;
   logic [11:7] addr_des;
   logic [31:0] pc_plus4;

   mem_state_t  state;
   logic [7:0]  cnt;
   logic [7:0]  cnt_next;
   logic        mem_op;
   logic        aligned;
   logic        misalign;
   logic        req;
   logic        stall;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [15:0] lane;
   logic [31:0] load_data;

   reg_mem u_reg_mem (
      .clk          (i_clk),
      .rst_n        (i_rst_n),
      .en           (!stall),
      .reg_write_d  (i_reg_write_EX),
      .result_src_d (i_result_src_EX),
      .mem_write_d  (i_mem_write_EX),
      .funct3_d     (i_funct3_EX),
      .alu_result_d (i_alu_result_EX),
      .write_data_d (i_write_data_EX),
      .addr_des_d   (i_addr_des_EX),
      .pc_plus4_d   (i_pc_plus4_EX),
      .reg_write_q  (reg_write),
      .result_src_q (result_src),
      .mem_write_q  (mem_write),
      .funct3_q     (funct3),
      .alu_result_q (alu_result),
      .write_data_q (write_data),
      .addr_des_q   (addr_des),
      .pc_plus4_q   (pc_plus4)
   );

   assign mem_op = (result_src == RES_MEM) || mem_write;

   // Size code 11 has no RV32I meaning and is dropped like a misaligned access.
   always_comb begin
      // NOTE: default assigned first so every path drives the signal and no latch is inferred.
      aligned = 1'b0;
      case (funct3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = !alu_result[0];
         2'b10:   aligned = (alu_result[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   assign misalign = mem_op && !aligned;
   assign req      = mem_op && aligned && (state != ABORT);
   assign stall    = req && !i_dmem_ready;
   assign cnt_next = cnt + 8'd1;

   always_comb begin
      be    = 4'b0000;
      wdata = write_data;
      case (funct3[1:0])
         2'b00: begin
            be    = 4'b0001 << alu_result[1:0];
            wdata = {4{write_data[7:0]}};
         end
         2'b01: begin
            be    = alu_result[1] ? 4'b1100 : 4'b0011;
            wdata = {2{write_data[15:0]}};
         end
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   always_comb begin
      load_data = 32'h0;
      lane      = 16'(i_dmem_rdata >> {alu_result[1:0], 3'b000});
      if (result_src == RES_MEM) begin
         case (funct3)
            F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
            F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   load_data = {24'h0, lane[7:0]};
            F3_HU:   load_data = {16'h0, lane[15:0]};
            default: load_data = i_dmem_rdata;
         endcase
      end
   end

   // IDLE and WAIT share the count-up path; cnt is 0 in IDLE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         cnt   <= 8'd0;
      end else begin
         case (state)
            IDLE, WAIT: begin
               if (stall) begin
                  cnt   <= cnt_next;
                  state <= (cnt_next == TIMEOUT_CNT) ? ABORT : WAIT;
               end else begin
                  cnt   <= 8'd0;
                  state <= IDLE;
               end
            end
            ABORT: begin
               cnt   <= 8'd0;
               state <= IDLE;
            end
            default: begin
               cnt   <= 8'd0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign o_dmem_req   = req;
   assign o_dmem_we    = mem_write;
   assign o_dmem_addr  = {alu_result[31:2], 2'b00};
   assign o_dmem_be    = req ? be : 4'b0000;
   assign o_dmem_wdata = wdata;

   // Write-back must not capture a stalled, aborted or dropped result.
   assign o_reg_write_MEM  = reg_write && !stall && (state != ABORT) && !misalign;
   assign o_result_src_MEM = result_src;
   assign o_alu_result_MEM = alu_result;
   assign o_data_MEM       = load_data;
   assign o_addr_des_MEM   = addr_des;
   assign o_pc_plus4_MEM   = pc_plus4;
   assign o_stall_MEM      = stall;
   assign o_misalign       = misalign;
   assign o_bus_err        = (state == ABORT);

endmodule
